// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state encoding and default widths for the SPI master
package spi_pkg;
  localparam int DWIDTH_DEF = 8;
  localparam int DIVW_DEF = 8;
  typedef enum logic [2:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL, S_DONE} spi_state_e;
endpackage

// File: rtl/spi_clkgen.sv
// spi_clkgen: half-period divider, one-cycle tick every i_div+1 enabled cycles
module spi_clkgen
  import spi_pkg::*;
#(
  parameter int DIVW = DIVW_DEF
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic            i_en,
  input  logic [DIVW-1:0] i_div,
  output logic            o_tick
);
  logic [DIVW-1:0] r_cnt;
  assign o_tick = i_en && (r_cnt == i_div);
  // count up to i_div then wrap; held at zero while idle so each frame starts aligned
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) r_cnt <= '0;
    else r_cnt <= (!i_en || o_tick) ? '0 : r_cnt + DIVW'(1);
endmodule

// File: rtl/spi_master.sv
// spi_master: single-frame SPI master with configurable CPOL/CPHA and SCLK divider
module spi_master
  import spi_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DIVW = DIVW_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              start,
  input  logic [DWIDTH-1:0] tx_data,
  input  logic [DIVW-1:0]   clk_div,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic [DWIDTH-1:0] rx_data,
  output logic              busy,
  output logic              done
);
  localparam int EW = $clog2(2 * DWIDTH + 1);
  localparam logic [EW-1:0] LAST = EW'(2 * DWIDTH);
  spi_state_e        r_state;
  logic [DIVW-1:0]   r_div;
  logic              r_cpol, r_cpha, r_sclk, r_mosi, r_cs_n, r_busy, r_done;
  logic [DWIDTH-1:0] r_tx, r_rx, r_rx_data;
  logic [EW-1:0]     r_edge;
  logic              w_tick, w_run, w_sample;
  logic [EW-1:0]     w_edge;
  assign w_run = (r_state == S_LEAD) || (r_state == S_XFER) || (r_state == S_TRAIL);
  assign w_edge = r_edge + EW'(1);
  assign w_sample = w_edge[0] ^ r_cpha;
  assign sclk = r_sclk;
  assign mosi = r_mosi;
  assign cs_n = r_cs_n;
  assign rx_data = r_rx_data;
  assign busy = r_busy;
  assign done = r_done;
  spi_clkgen #(.DIVW(DIVW)) u_clkgen (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .i_en(w_run),
    .i_div(r_div),
    .o_tick(w_tick)
  );
  // frame sequencer: latches the configuration at start, then walks LEAD/XFER/TRAIL/DONE
  always_ff @(posedge PCLK or negedge PRESETn)
    if (!PRESETn) begin
      r_state <= S_IDLE;
      r_div <= '0;
      r_cpol <= 1'b0;
      r_cpha <= 1'b0;
      r_sclk <= 1'b0;
      r_mosi <= 1'b0;
      r_cs_n <= 1'b1;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_tx <= '0;
      r_rx <= '0;
      r_rx_data <= '0;
      r_edge <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_sclk <= cpol;
          r_mosi <= 1'b0;
          if (start) begin
            r_state <= S_LEAD;
            r_cs_n <= 1'b0;
            r_busy <= 1'b1;
            r_div <= clk_div;
            r_cpol <= cpol;
            r_cpha <= cpha;
            r_edge <= '0;
            r_tx <= cpha ? tx_data : {tx_data[DWIDTH-2:0], 1'b0};
            r_mosi <= !cpha && tx_data[DWIDTH-1];
          end
        end
        S_LEAD: if (w_tick) r_state <= S_XFER;
        S_XFER: if (w_tick) begin
          r_sclk <= ~r_sclk;
          r_edge <= w_edge;
          if (w_sample) r_rx <= {r_rx[DWIDTH-2:0], miso};
          else if (w_edge != LAST) begin
            r_mosi <= r_tx[DWIDTH-1];
            r_tx <= {r_tx[DWIDTH-2:0], 1'b0};
          end
          if (w_edge == LAST) r_state <= S_TRAIL;
        end
        S_TRAIL: if (w_tick) begin
          r_state <= S_DONE;
          r_cs_n <= 1'b1;
          r_done <= 1'b1;
          r_rx_data <= r_rx;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy <= 1'b0;
          r_mosi <= 1'b0;
          r_sclk <= r_cpol;
        end
        default: r_state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: scoreboard-driven checks of framing, modes, latching and reset
module tb_spi_master;
  logic       PCLK = 1'b0;
  logic       PRESETn = 1'b0;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] clk_div = 8'd1;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       miso;
  logic       sclk, mosi, cs_n, busy, done;
  logic [7:0] rx_data;
  bit         loop = 1'b0;
  logic       miso_val = 1'b0;
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         cyc, edges, cslow;
  logic [7:0] cap;
  bit         got;
  assign miso = loop ? mosi : miso_val;
  always #5 PCLK = ~PCLK;
  spi_master #(.DWIDTH(8), .DIVW(8)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .start(start), .tx_data(tx_data),
    .clk_div(clk_div), .cpol(cpol), .cpha(cpha), .miso(miso),
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .rx_data(rx_data),
    .busy(busy), .done(done)
  );
  // mode: 0 plain, 1 extra start mid-frame, 2 change inputs in XFER, 3 stop after edge 5
  task automatic run_frame(input logic [7:0] tx, input logic [7:0] div, input logic p,
                           input logic h, input int mode);
    logic ps, stop;
    logic [7:0] e;
    int want;
    @(negedge PCLK);
    tx_data = tx; clk_div = div; cpol = p; cpha = h;
    repeat (2) @(negedge PCLK);
    start = 1'b1;
    exp_q.push_back(loop ? tx : (miso_val ? 8'hFF : 8'h00));
    want = 18 * (int'(div) + 1) + 1;
    cyc = 0; edges = 0; cslow = 0; cap = 8'h00; got = 1'b0; stop = 1'b0; ps = sclk;
    while (!got && !stop && cyc < 6000) begin
      @(negedge PCLK);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1 || cs_n !== 1'b0) begin
          errors++; $display("FAIL frame_begin busy=%b cs_n=%b required busy=1 cs_n=0", busy, cs_n);
        end
      end
      if (cs_n === 1'b0) cslow++;
      if (sclk !== ps) begin
        edges++;
        if (edges[0] ^ h) cap = {cap[6:0], mosi};
      end
      ps = sclk;
      if (mode == 1 && cyc == 5) start = 1'b1;
      if (mode == 2 && edges == 3) begin tx_data = 8'h00; cpol = ~p; cpha = ~h; clk_div = 8'd7; end
      if (mode == 3 && edges == 5) stop = 1'b1;
      if (done === 1'b1) got = 1'b1;
    end
    if (stop) e = exp_q.pop_front();
    else begin
      checks++;
      if (!got) begin errors++; $display("FAIL done_timeout cycles=%0d required done", cyc); end
      else begin
        e = exp_q.pop_front();
        checks++;
        if (rx_data !== e) begin errors++; $display("FAIL rx_data got=%h required=%h", rx_data, e); end
        checks++;
        if (cyc != want) begin errors++; $display("FAIL frame_len got=%0d required=%0d", cyc, want); end
        @(negedge PCLK);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || cs_n !== 1'b1) begin
          errors++; $display("FAIL after_done done=%b busy=%b cs_n=%b required 0 0 1", done, busy, cs_n);
        end
      end
    end
  endtask
  task automatic test_reset;
    @(negedge PCLK);
    checks++;
    if ({cs_n, sclk, mosi, busy, done} !== 5'b10000 || rx_data !== 8'h00) begin
      errors++; $display("FAIL reset cs_n/sclk/mosi/busy/done=%b rx=%h required 10000 00",
                         {cs_n, sclk, mosi, busy, done}, rx_data);
    end
    PRESETn = 1'b1;
  endtask
  task automatic test_idle;
    @(negedge PCLK); cpol = 1'b1;
    repeat (2) @(negedge PCLK);
    checks++;
    if (sclk !== 1'b1 || mosi !== 1'b0) begin
      errors++; $display("FAIL idle_cpol1 sclk=%b mosi=%b required 1 0", sclk, mosi);
    end
    cpol = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++;
    if (sclk !== 1'b0) begin errors++; $display("FAIL idle_cpol0 sclk=%b required 0", sclk); end
  endtask
  task automatic test_loopback;
    loop = 1'b1;
    run_frame(8'hA5, 8'd1, 1'b0, 1'b0, 0);
    checks++;
    if (cap !== 8'hA5) begin errors++; $display("FAIL loop_mosi got=%h required=a5", cap); end
    checks++;
    if (cyc != 37) begin errors++; $display("FAIL loop_len got=%0d required=37", cyc); end
    checks++;
    if (edges != 16) begin errors++; $display("FAIL loop_edges got=%0d required=16", edges); end
  endtask
  task automatic test_cpol1_cpha1;
    loop = 1'b0; miso_val = 1'b1;
    @(negedge PCLK); cpol = 1'b1;
    repeat (2) @(negedge PCLK);
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL m3_idle sclk=%b required 1", sclk); end
    run_frame(8'h3C, 8'd1, 1'b1, 1'b1, 0);
    checks++;
    if (edges != 16) begin errors++; $display("FAIL m3_edges got=%0d required=16", edges); end
    checks++;
    if (cslow != 36) begin errors++; $display("FAIL m3_cs_low got=%0d required=36", cslow); end
    checks++;
    if (cap !== 8'h3C) begin errors++; $display("FAIL m3_mosi got=%h required=3c", cap); end
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL m3_idle_after sclk=%b required 1", sclk); end
  endtask
  task automatic test_ignore_start;
    int extra;
    loop = 1'b1;
    run_frame(8'h5A, 8'd0, 1'b0, 1'b0, 1);
    extra = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge PCLK);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin errors++; $display("FAIL ignore_start extra_activity=%0d required=0", extra); end
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left got=%0d required=0", exp_q.size()); end
  endtask
  task automatic test_reset_midframe;
    loop = 1'b1;
    run_frame(8'h6E, 8'd1, 1'b0, 1'b0, 3);
    PRESETn = 1'b0;
    #1;
    checks++;
    if (cs_n !== 1'b1 || busy !== 1'b0 || rx_data !== 8'h00 || sclk !== 1'b0 || mosi !== 1'b0) begin
      errors++; $display("FAIL mid_reset cs_n=%b busy=%b rx=%h sclk=%b mosi=%b required 1 0 00 0 0",
                         cs_n, busy, rx_data, sclk, mosi);
    end
    repeat (2) @(negedge PCLK);
    PRESETn = 1'b1;
    repeat (3) @(negedge PCLK);
    checks++;
    if (busy !== 1'b0 || cs_n !== 1'b1) begin
      errors++; $display("FAIL no_resume busy=%b cs_n=%b required 0 1", busy, cs_n);
    end
    run_frame(8'h81, 8'd1, 1'b0, 1'b0, 0);
    checks++;
    if (cap !== 8'h81) begin errors++; $display("FAIL post_reset_mosi got=%h required=81", cap); end
  endtask
  task automatic test_latch;
    loop = 1'b1;
    run_frame(8'h96, 8'd1, 1'b0, 1'b0, 2);
    checks++;
    if (cap !== 8'h96) begin errors++; $display("FAIL latch_mosi got=%h required=96", cap); end
    checks++;
    if (edges != 16) begin errors++; $display("FAIL latch_edges got=%0d required=16", edges); end
  endtask
  task automatic test_max_div;
    loop = 1'b1;
    run_frame(8'hC3, 8'hFF, 1'b0, 1'b1, 0);
    checks++;
    if (cap !== 8'hC3) begin errors++; $display("FAIL maxdiv_mosi got=%h required=c3", cap); end
  endtask
  initial begin
    test_reset();
    test_idle();
    test_loopback();
    test_cpol1_cpha1();
    test_ignore_start();
    test_reset_midframe();
    test_latch();
    test_max_div();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_master.md
SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL have parameter DWIDTH, default 8: SPI frame width and tx/rx data width in bits, minimum 2.
REQ-002 SHALL have parameter DIVW, default 8: width of the clock-divider input.
REQ-003 SHALL have port PCLK  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port PRESETn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
REQ-006 SHALL have port tx_data  input  DWIDTH  frame to transmit, driven from the write register.
REQ-007 SHALL have port clk_div  input  DIVW  half-period of SCLK, expressed as clk_div+1 PCLK cycles.
REQ-008 SHALL have port cpol  input  1  SCLK idle level.
REQ-009 SHALL have port cpha  input  1  0 = sample on the leading edge; 1 = sample on the trailing edge.
REQ-010 SHALL have port miso  input  1  serial data in, already synchronous to PCLK.
REQ-011 SHALL have port sclk  output  1  SPI clock.
REQ-012 SHALL have port mosi  output  1  serial data out, MSB first.
REQ-013 SHALL have port cs_n  output  1  active-low chip select.
REQ-014 SHALL have port rx_data  output  DWIDTH  last complete received frame, held until the next frame completes.
REQ-015 SHALL have port busy  output  1  high from start acceptance until the end of DONE.
REQ-016 SHALL have port done  output  1  one-cycle pulse when rx_data is updated.

Function
REQ-017 SHALL implement FSM states IDLE, LEAD, XFER, TRAIL, DONE.
REQ-018 IDLE: on start=1, SHALL latch tx_data, clk_div, cpol and cpha, assert cs_n=0 and busy=1, and go to LEAD; input changes later in the frame SHALL have no effect.
REQ-019 LEAD SHALL last exactly one half-period with sclk=cpol, then go to XFER.
REQ-020 XFER SHALL toggle sclk once per half-period, for exactly 2*DWIDTH edges, then go to TRAIL.
REQ-021 With cpha=0, mosi SHALL present the MSB on entry to LEAD, sample miso on each odd-numbered edge, and shift mosi on each even-numbered edge except the last.
REQ-022 With cpha=1, mosi SHALL shift on each odd-numbered edge (MSB on edge 1) and sample miso on each even-numbered edge.
REQ-023 TRAIL SHALL last one half-period with sclk=cpol, then go to DONE.
REQ-024 DONE SHALL last one cycle: cs_n=1, rx_data loaded with the shifted-in frame, done=1; next state IDLE with busy=0.
REQ-025 A start asserted while busy=1 SHALL be ignored (not queued).
REQ-026 clk_div=0 SHALL give a half-period of 1 PCLK; clk_div=all-ones SHALL give 2^DIVW PCLK with no counter overflow.
REQ-027 The total frame length from the start cycle to done SHALL be (2*DWIDTH+2)*(clk_div+1)+1 PCLK cycles.
REQ-028 In IDLE, sclk SHALL follow the live cpol input and mosi SHALL be 0.

Reset
REQ-029 On PRESETn=0, at any time including mid-frame, the block SHALL immediately force: state=IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, divider counter=0, edge counter=0.
REQ-030 After PRESETn deasserts, the first start SHALL be accepted normally; no partial frame SHALL resume.

Structure
REQ-031 A shared package spi_pkg SHALL hold the FSM state enum and the default DWIDTH/DIVW constants.
REQ-032 The half-period divider SHALL be a sub-module spi_clkgen that outputs a one-cycle tick; the FSM and shift registers SHALL remain in spi_master.

Verification
REQ-033 DWIDTH=8, clk_div=1, cpol=0, cpha=0, tx_data=0xA5, loopback miso=mosi -> mosi bits 1,0,1,0,0,1,0,1; rx_data=0xA5; done after 37 cycles.
REQ-034 cpol=1, cpha=1, tx_data=0x3C, miso tied to 1 -> sclk idles high and has 16 edges; rx_data=0xFF; cs_n low for 36 cycles.
REQ-035 clk_div=0, start pulsed again mid-frame -> exactly one done pulse; the second start is ignored.
REQ-036 PRESETn pulsed low after SCLK edge 5 -> cs_n=1, busy=0, rx_data=0 in the same cycle; the next frame with 0x81 completes correctly.
REQ-037 tx_data and cpol changed during XFER -> the frame still transmits the latched values.
